tail_lamp_sequencer: RTL and testbench

TAIL_LAMP_SEQUENCER -- requirements
Module: tail_lamp_sequencer

---
 rtl/tail_lamp_sequencer.sv | 159 +++++++++++++++
 tb/tb_tail_lamp_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tail_lamp_sequencer.sv
// tail_lamp_sequencer
//   Rear turn/hazard lamp sequencer. A prescaler divides CLOCK down to a
//   step tick. On each tick the mode/step state machine advances a
//   three-lamp sweep: 000 -> 001 -> 011 -> 111 -> 000. The sweep is shown
//   on the left side, the right side, or both sides (hazard).
//
//   Optional feature macro: BRAKE_EN. When it is defined, the BRAKE port
//   exists and lights every side that is not sweeping to 111. Hazard
//   ignores BRAKE.
//
// Parameters
//   TICK_DIV     clock cycles per sweep step (1..65535)
// Ports
//   CLOCK        rising-edge clock
//   RESET        asynchronous, active-high reset
//   EMERGENCY    hazard request (highest priority, sampled on ticks)
//   TURN_LEFT    left turn request (sampled on ticks)
//   TURN_RIGHT   right turn request (sampled on ticks)
//   BRAKE        brake request, every cycle (only with BRAKE_EN)
//   LEFT_LAMP    left lamps, bit0 innermost .. bit2 outermost (registered)
//   RIGHT_LAMP   right lamps, bit0 innermost .. bit2 outermost (registered)
//   ACTIVE_MODE  00 idle, 01 left, 10 right, 11 hazard (registered)
module tail_lamp_sequencer #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       EMERGENCY,
    input  logic       TURN_LEFT,
    input  logic       TURN_RIGHT,
`ifdef BRAKE_EN
    input  logic       BRAKE,
`endif
    output logic [2:0] LEFT_LAMP,
    output logic [2:0] RIGHT_LAMP,
    output logic [1:0] ACTIVE_MODE
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } mode_t;

    logic [15:0] count_p0;
    logic        tick_p0;
    mode_t       mode_p0;
    logic [1:0]  step_p0;

    logic [2:0]  sweep;
    logic [2:0]  left_nxt;
    logic [2:0]  right_nxt;
    logic [2:0]  left_p1;
    logic [2:0]  right_p1;
    logic [1:0]  mode_p1;

    function automatic logic [2:0] sweep_pattern(input logic [1:0] step);
        logic [2:0] pat;
        case (step)
            2'd1:    pat = 3'b001;
            2'd2:    pat = 3'b011;
            2'd3:    pat = 3'b111;
            default: pat = 3'b000;
        endcase
        return pat;
    endfunction

    // Stage p0: prescaler and mode/step state
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            count_p0 <= 16'd0;
        end else if (count_p0 == TICK_LAST) begin
            count_p0 <= 16'd0;
        end else begin
            count_p0 <= count_p0 + 16'd1;
        end
    end

    assign tick_p0 = (count_p0 == TICK_LAST);

    // Requests are looked at only on ticks, so pulses between ticks are lost.
    // IDLE always carries step 0, so a non-zero step means a sweep in flight.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            mode_p0 <= IDLE;
            step_p0 <= 2'd0;
        end else if (tick_p0) begin
            if (EMERGENCY) begin
                if (mode_p0 != HAZARD) begin
                    mode_p0 <= HAZARD;
                    step_p0 <= 2'd1;
                end else begin
                    step_p0 <= step_p0 + 2'd1;
                end
            end else if (mode_p0 == HAZARD) begin
                mode_p0 <= IDLE;
                step_p0 <= 2'd0;
            end else if (step_p0 != 2'd0) begin
                step_p0 <= step_p0 + 2'd1;
            end else if (TURN_LEFT && !TURN_RIGHT) begin
                mode_p0 <= LEFT;
                step_p0 <= 2'd1;
            end else if (TURN_RIGHT && !TURN_LEFT) begin
                mode_p0 <= RIGHT;
                step_p0 <= 2'd1;
            end else begin
                mode_p0 <= IDLE;
                step_p0 <= 2'd0;
            end
        end
    end

    always_comb begin
        sweep     = sweep_pattern(step_p0);
        left_nxt  = 3'b000;
        right_nxt = 3'b000;
        case (mode_p0)
            LEFT:    left_nxt = sweep;
            RIGHT:   right_nxt = sweep;
            HAZARD: begin
                left_nxt  = sweep;
                right_nxt = sweep;
            end
            default: ;
        endcase
`ifdef BRAKE_EN
        // Brake fills whichever side is not sweeping; hazard owns both sides.
        if (BRAKE && (mode_p0 != HAZARD)) begin
            if (mode_p0 != LEFT) begin
                left_nxt = 3'b111;
            end
            if (mode_p0 != RIGHT) begin
                right_nxt = 3'b111;
            end
        end
`endif
    end

    // Stage p1: registered lamp and mode outputs
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            left_p1  <= 3'b000;
            right_p1 <= 3'b000;
            mode_p1  <= 2'b00;
        end else begin
            left_p1  <= left_nxt;
            right_p1 <= right_nxt;
            mode_p1  <= mode_p0;
        end
    end

    assign LEFT_LAMP   = left_p1;
    assign RIGHT_LAMP  = right_p1;
    assign ACTIVE_MODE = mode_p1;

endmodule

// File: tb/tb_tail_lamp_sequencer.sv
// tb_tail_lamp_sequencer
//   Directed bench for tail_lamp_sequencer with TICK_DIV=4. A table of
//   per-cycle {inputs, expected outputs} records covers the left sweep,
//   the left-to-right handover, hazard entry and exit, and both turns
//   requested at once. Hand-written sequences cover asynchronous reset
//   mid-sweep and, when BRAKE_EN is defined, the brake behaviour.
module tb_tail_lamp_sequencer;

    logic       clk;
    logic       rst;
    logic       emergency;
    logic       turn_left;
    logic       turn_right;
`ifdef BRAKE_EN
    logic       brake;
`endif
    logic [2:0] left_lamp;
    logic [2:0] right_lamp;
    logic [1:0] active_mode;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       e;
        logic       tl;
        logic       tr;
        logic [2:0] exp_l;
        logic [2:0] exp_r;
        logic [1:0] exp_m;
    } vec_t;

    vec_t vecs[$];

    tail_lamp_sequencer #(.TICK_DIV(4)) dut (
        .CLOCK      (clk),
        .RESET      (rst),
        .EMERGENCY  (emergency),
        .TURN_LEFT  (turn_left),
        .TURN_RIGHT (turn_right),
`ifdef BRAKE_EN
        .BRAKE      (brake),
`endif
        .LEFT_LAMP  (left_lamp),
        .RIGHT_LAMP (right_lamp),
        .ACTIVE_MODE(active_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] l, input logic [2:0] r,
                             input logic [1:0] m);
        check({tag, " left"},  {1'b0, left_lamp},   {1'b0, l});
        check({tag, " right"}, {1'b0, right_lamp},  {1'b0, r});
        check({tag, " mode"},  {2'b00, active_mode}, {2'b00, m});
    endtask

    task automatic add_run(input int n, input logic e, input logic tl, input logic tr,
                           input logic [2:0] l, input logic [2:0] r, input logic [1:0] m);
        vec_t v;
        v.e = e; v.tl = tl; v.tr = tr; v.exp_l = l; v.exp_r = r; v.exp_m = m;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        emergency  = 1'b0;
        turn_left  = 1'b0;
        turn_right = 1'b0;
`ifdef BRAKE_EN
        brake      = 1'b0;
`endif

        // Vector k is applied before rising edge k+1 after reset release,
        // and checked 1 time unit after that edge. Edges 4, 8, 12... are ticks.
        add_run(4, 0, 1, 0, 3'b000, 3'b000, 2'b00);  // edges 1-4: nothing yet
        add_run(4, 0, 1, 0, 3'b001, 3'b000, 2'b01);  // left sweep starts
        add_run(4, 0, 1, 0, 3'b011, 3'b000, 2'b01);
        add_run(4, 0, 1, 0, 3'b111, 3'b000, 2'b01);
        add_run(4, 0, 1, 0, 3'b000, 3'b000, 2'b01);  // step 0, still LEFT
        add_run(4, 0, 1, 0, 3'b001, 3'b000, 2'b01);  // sweep repeats
        add_run(4, 0, 0, 1, 3'b011, 3'b000, 2'b01);  // right requested mid-sweep
        add_run(4, 0, 0, 1, 3'b111, 3'b000, 2'b01);  // left completes
        add_run(4, 0, 0, 1, 3'b000, 3'b000, 2'b01);
        add_run(4, 0, 0, 1, 3'b000, 3'b001, 2'b10);  // right starts
        add_run(4, 0, 0, 1, 3'b000, 3'b011, 2'b10);
        add_run(4, 0, 1, 0, 3'b000, 3'b111, 2'b10);  // left requested mid-sweep
        add_run(4, 0, 1, 0, 3'b000, 3'b000, 2'b10);
        add_run(4, 0, 1, 0, 3'b001, 3'b000, 2'b01);
        add_run(1, 0, 1, 0, 3'b011, 3'b000, 2'b01);
        add_run(1, 1, 1, 0, 3'b011, 3'b000, 2'b01);  // emergency pulse off-tick: ignored
        add_run(1, 0, 1, 0, 3'b011, 3'b000, 2'b01);
        add_run(1, 1, 1, 0, 3'b011, 3'b000, 2'b01);  // emergency at tick, step 2
        add_run(4, 1, 0, 0, 3'b001, 3'b001, 2'b11);  // hazard preempts
        add_run(4, 0, 0, 0, 3'b011, 3'b011, 2'b11);  // hazard advanced, then drop
        add_run(4, 0, 1, 1, 3'b000, 3'b000, 2'b00);  // back to idle
        add_run(12, 0, 1, 1, 3'b000, 3'b000, 2'b00); // both turns: stay idle

        #1 rst = 1'b1;
        #1 check_all("async reset", 3'b000, 3'b000, 2'b00);
        @(posedge clk); #1;
        check_all("reset held", 3'b000, 3'b000, 2'b00);
        @(negedge clk) rst = 1'b0;

        foreach (vecs[i]) begin
            emergency  = vecs[i].e;
            turn_left  = vecs[i].tl;
            turn_right = vecs[i].tr;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r, vecs[i].exp_m);
        end

        // Reset in the middle of a left sweep. After the table the prescaler
        // is at 0 again; TURN_LEFT gives step 1 at edge 88, step 2 at 92.
        emergency  = 1'b0;
        turn_left  = 1'b1;
        turn_right = 1'b0;
        repeat (9) @(posedge clk);
        #1 check_all("pre-reset sweep", 3'b011, 3'b000, 2'b01);
        #2 rst = 1'b1;
        #1 check_all("mid-sweep reset", 3'b000, 3'b000, 2'b00);
        @(posedge clk); #1;
        check_all("mid-sweep reset held", 3'b000, 3'b000, 2'b00);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all("post-reset edge3", 3'b000, 3'b000, 2'b00);
        repeat (2) @(posedge clk);
        #1 check_all("post-reset edge5", 3'b001, 3'b000, 2'b01);

`ifdef BRAKE_EN
        // Edge 5 after release: LEFT step 1 showing. Brake fills the right side.
        brake = 1'b1;
        @(posedge clk); #1;
        check_all("brake in left", 3'b001, 3'b111, 2'b01);
        brake = 1'b0;
        @(posedge clk); #1;
        check_all("brake released", 3'b001, 3'b000, 2'b01);
        emergency = 1'b1;
        @(posedge clk); #1;   // edge 8: tick enters hazard
        brake = 1'b1;
        @(posedge clk); #1;
        check_all("brake in hazard", 3'b001, 3'b001, 2'b11);
        brake     = 1'b0;
        emergency = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
